// File: rtl/u_rec_frame.sv
// UART receiver: 2-flop synchronised line, mid-cell sampling, LSB-first data, stop-bit check; byte held until acked.
// Byte is ready 2+(WORD_LEN+1)*BIT_CLKS+BIT_CLKS/2 edges after the start edge; the line cannot be stalled, so an unacked byte is overwritten and flagged.
module u_rec_frame #(
  parameter int WORD_LEN = 8,
  parameter int BIT_CLKS = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                uart_recH,
  output logic [WORD_LEN-1:0] rec_dataH,
  output logic                rec_readyH,
  input  logic                rec_ackH,
  output logic                overrun_errH,
  output logic                frame_errH,
  output logic                rec_busyH
);

  localparam int CW = $clog2(BIT_CLKS);
  localparam int BW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [CW-1:0] SMP_CNT  = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0] END_CNT  = CW'(BIT_CLKS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_LEN - 1);

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_START = 3'd1,
    R_DATA  = 3'd2,
    R_STOP  = 3'd3,
    R_BREAK = 3'd4
  } recState_t;

  recState_t           state;
  recState_t           nextState;
  logic                rxMeta;
  logic                rxS;
  logic [CW-1:0]       cellCntr;
  logic [BW-1:0]       bitCnt;
  logic [WORD_LEN-1:0] shreg;
  logic                smpHit;
  logic                endHit;
  logic                cntActive;
  logic                shiftEn;
  logic                goodFrame;
  logic                frameErr;
  logic                ackTaken;

  assign smpHit    = (cellCntr == SMP_CNT);
  assign endHit    = (cellCntr == END_CNT);
  assign cntActive = (state == R_START) || (state == R_DATA) || (state == R_STOP);
  assign ackTaken  = rec_ackH && rec_readyH;
  assign rec_busyH = (state != R_IDLE);

  always_comb begin
    nextState = state;
    shiftEn   = 1'b0;
    goodFrame = 1'b0;
    frameErr  = 1'b0;
    case (state)
      R_IDLE: begin
        if (!rxS) nextState = R_START;
      end
      R_START: begin
        // Line back HI at mid start cell means a glitch, not a frame
        if (smpHit && rxS)  nextState = R_IDLE;
        else if (endHit)    nextState = R_DATA;
      end
      R_DATA: begin
        shiftEn = smpHit;
        if (endHit && (bitCnt == LAST_BIT)) nextState = R_STOP;
      end
      R_STOP: begin
        if (smpHit) begin
          if (rxS) begin
            goodFrame = 1'b1;
            nextState = R_IDLE;
          end else begin
            frameErr  = 1'b1;
            nextState = R_BREAK;
          end
        end
      end
      R_BREAK: begin
        if (rxS) nextState = R_IDLE;
      end
      default: nextState = R_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= R_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rxMeta       <= 1'b1;
      rxS          <= 1'b1;
      cellCntr     <= '0;
      bitCnt       <= '0;
      shreg        <= '0;
      rec_dataH    <= '0;
      rec_readyH   <= 1'b0;
      overrun_errH <= 1'b0;
      frame_errH   <= 1'b0;
    end else begin
      rxMeta     <= uart_recH;
      rxS        <= rxMeta;
      frame_errH <= frameErr;

      if (nextState != state)  cellCntr <= '0;
      else if (!cntActive)     cellCntr <= '0;
      else if (endHit)         cellCntr <= '0;
      else                     cellCntr <= cellCntr + CW'(1);

      if ((state == R_IDLE) && (nextState == R_START))
        bitCnt <= '0;
      else if ((state == R_DATA) && endHit && (bitCnt != LAST_BIT))
        bitCnt <= bitCnt + BW'(1);

      if (shiftEn)
        shreg <= (shreg >> 1) | (WORD_LEN'(rxS) << (WORD_LEN - 1));

      // A byte landing in the ack cycle replaces the acked one cleanly
      if (goodFrame) begin
        rec_dataH  <= shreg;
        rec_readyH <= 1'b1;
        if (rec_readyH && !rec_ackH) overrun_errH <= 1'b1;
        else if (ackTaken)           overrun_errH <= 1'b0;
      end else if (ackTaken) begin
        rec_readyH   <= 1'b0;
        overrun_errH <= 1'b0;
      end
    end
  end

endmodule
